// File: rtl/input_switch.sv
// Routes one shared, synchronised and glitch-filtered 8-bit pin bus to CPU A or CPU B,
// holding both CPU-side buses idle for a guard interval on every changeover.
module input_switch #(
   parameter logic [7:0] IDLE_VALUE   = 8'hFF,
   parameter int         FILTER_LEN   = 4,
   parameter int         GUARD_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ctr_io,
   input  logic [7:0] input_pin,
   output logic [7:0] input_to_A,
   output logic [7:0] input_to_B,
   output logic       active_sel,
   output logic       switching
);

   typedef enum logic [1:0] {
      ACTIVE_A = 2'd0,
      ACTIVE_B = 2'd1,
      GUARD    = 2'd2
   } state_t;

   localparam logic [7:0] FILT_LAST  = 8'(FILTER_LEN - 1);
   localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES - 1);

   logic [7:0] pinMeta_q, pinSync_q;
   logic       ctrMeta_q, ctrSync_q;

   logic [7:0] cand_q, cand_d;
   logic [7:0] filt_q, filt_d;
   logic [7:0] fcnt_q, fcnt_d;

   state_t     state_q, state_d;
   logic [7:0] gcnt_q, gcnt_d;
   logic       target_q, target_d;
   logic       activeSel_q, activeSel_d;

   logic [7:0] outA_q, outA_d;
   logic [7:0] outB_q, outB_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pinMeta_q <= IDLE_VALUE;
         pinSync_q <= IDLE_VALUE;
         ctrMeta_q <= 1'b0;
         ctrSync_q <= 1'b0;
      end else begin
         pinMeta_q <= input_pin;
         pinSync_q <= pinMeta_q;
         ctrMeta_q <= ctr_io;
         ctrSync_q <= ctrMeta_q;
      end
   end

   // Whole-byte filter: any change restarts the count, so a glitch never reaches filt.
   always_comb begin
      cand_d = cand_q;
      fcnt_d = fcnt_q;
      filt_d = filt_q;
      if (pinSync_q != cand_q) begin
         cand_d = pinSync_q;
         fcnt_d = 8'd0;
      end else if (fcnt_q < FILT_LAST) begin
         fcnt_d = fcnt_q + 8'd1;
      end else begin
         filt_d = cand_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_q <= IDLE_VALUE;
         filt_q <= IDLE_VALUE;
         fcnt_q <= 8'd0;
      end else begin
         cand_q <= cand_d;
         filt_q <= filt_d;
         fcnt_q <= fcnt_d;
      end
   end

   // A select change during guard restarts the interval towards the newest target.
   always_comb begin
      state_d     = state_q;
      gcnt_d      = gcnt_q;
      target_d    = target_q;
      activeSel_d = activeSel_q;
      unique case (state_q)
         ACTIVE_A: begin
            if (ctrSync_q) begin
               state_d  = GUARD;
               target_d = 1'b1;
               gcnt_d   = 8'd0;
            end
         end
         ACTIVE_B: begin
            if (!ctrSync_q) begin
               state_d  = GUARD;
               target_d = 1'b0;
               gcnt_d   = 8'd0;
            end
         end
         GUARD: begin
            if (ctrSync_q != target_q) begin
               target_d = ctrSync_q;
               gcnt_d   = 8'd0;
            end else if (gcnt_q == GUARD_LAST) begin
               state_d     = target_q ? ACTIVE_B : ACTIVE_A;
               activeSel_d = target_q;
            end else begin
               gcnt_d = gcnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ACTIVE_A;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACTIVE_A;
         gcnt_q      <= 8'd0;
         target_q    <= 1'b0;
         activeSel_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         gcnt_q      <= gcnt_d;
         target_q    <= target_d;
         activeSel_q <= activeSel_d;
      end
   end

   // Each CPU sees filt only while its own ACTIVE state holds, so both are never live together.
   always_comb begin
      outA_d = (state_q == ACTIVE_A) ? filt_q : IDLE_VALUE;
      outB_d = (state_q == ACTIVE_B) ? filt_q : IDLE_VALUE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outA_q <= IDLE_VALUE;
         outB_q <= IDLE_VALUE;
      end else begin
         outA_q <= outA_d;
         outB_q <= outB_d;
      end
   end

   assign input_to_A = outA_q;
   assign input_to_B = outB_q;
   assign active_sel = activeSel_q;
   assign switching  = (state_q == GUARD);

endmodule

// File: tb/tb_input_switch.sv
// Self-checking bench for input_switch: directed scenarios plus random pin/select traffic,
// all compared against a run-length based reference model.
module tb_input_switch;

   localparam logic [7:0] IDLE = 8'hFF;
   localparam int         FL   = 4;
   localparam int         GC   = 8;

   logic       clk;
   logic       rst_n;
   logic       ctr_io;
   logic [7:0] input_pin;
   logic [7:0] input_to_A;
   logic [7:0] input_to_B;
   logic       active_sel;
   logic       switching;

   int testCount;
   int failCount;

   // Reference model state: synchroniser delay, run lengths of the synchronised values, grant.
   logic [7:0] d1Pin, d2Pin;
   logic       d1Ctr, d2Ctr;
   logic [7:0] runPinVal;
   int         runPin;
   logic       runCtrVal;
   int         runCtr;
   logic [7:0] mFilt, mOutA, mOutB;
   logic       mGrant, mGuard;

   logic sawZeroA;
   logic sawLiveB;

   input_switch #(
      .IDLE_VALUE  (IDLE),
      .FILTER_LEN  (FL),
      .GUARD_CYCLES(GC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ctr_io    (ctr_io),
      .input_pin (input_pin),
      .input_to_A(input_to_A),
      .input_to_B(input_to_B),
      .active_sel(active_sel),
      .switching (switching)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      d1Pin     = IDLE;
      d2Pin     = IDLE;
      d1Ctr     = 1'b0;
      d2Ctr     = 1'b0;
      runPinVal = IDLE;
      runPin    = FL + 1;
      runCtrVal = 1'b0;
      runCtr    = 1;
      mFilt     = IDLE;
      mOutA     = IDLE;
      mOutB     = IDLE;
      mGrant    = 1'b0;
      mGuard    = 1'b0;
   endtask

   // Data is accepted once the synchronised byte has been seen FL+1 times in a row;
   // a new grant takes effect once the synchronised select has held GC+1 samples.
   task automatic modelStep();
      logic [7:0] sPin;
      logic       sCtr;
      sPin  = d2Pin;
      sCtr  = d2Ctr;
      d2Pin = d1Pin;
      d1Pin = input_pin;
      d2Ctr = d1Ctr;
      d1Ctr = ctr_io;
      mOutA = (!mGuard && !mGrant) ? mFilt : IDLE;
      mOutB = (!mGuard && mGrant) ? mFilt : IDLE;
      if (sPin == runPinVal) runPin++;
      else begin
         runPinVal = sPin;
         runPin    = 1;
      end
      if (runPin > FL) mFilt = runPinVal;
      if (sCtr == runCtrVal) runCtr++;
      else begin
         runCtrVal = sCtr;
         runCtr    = 1;
      end
      if (!mGuard) begin
         if (sCtr != mGrant) mGuard = 1'b1;
      end else if (runCtr > GC) begin
         mGuard = 1'b0;
         mGrant = sCtr;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      modelStep();
      checkOutput("toA", input_to_A, mOutA);
      checkOutput("toB", input_to_B, mOutB);
      checkOutput("activeSel", {7'd0, active_sel}, {7'd0, mGrant});
      checkOutput("switching", {7'd0, switching}, {7'd0, mGuard});
      checkOutput("exclusive", {7'd0, (input_to_A != IDLE) && (input_to_B != IDLE)}, 8'd0);
      if (input_to_A == 8'h00) sawZeroA = 1'b1;
      if (input_to_B != IDLE) sawLiveB = 1'b1;
   endtask

   task automatic applyStimulus(input logic [7:0] pin, input logic ctr, input int cycles);
      input_pin = pin;
      ctr_io    = ctr;
      repeat (cycles) tick();
   endtask

   initial begin
      testCount = 0;
      failCount = 0;
      sawZeroA  = 1'b0;
      sawLiveB  = 1'b0;
      modelReset();

      // Reset with select pointing at B and pins at zero
      rst_n     = 1'b0;
      input_pin = 8'h00;
      ctr_io    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_toA", input_to_A, 8'hFF);
      checkOutput("rst_toB", input_to_B, 8'hFF);
      checkOutput("rst_sel", {7'd0, active_sel}, 8'd0);
      checkOutput("rst_sw", {7'd0, switching}, 8'd0);
      rst_n = 1'b1;
      modelReset();
      applyStimulus(8'h00, 1'b1, 16);
      checkOutput("rst_B_granted", {7'd0, active_sel}, 8'd1);
      checkOutput("rst_B_data", input_to_B, 8'h00);

      // Filter latency on A
      applyStimulus(8'hFF, 1'b0, 30);
      applyStimulus(8'h5A, 1'b0, 7);
      checkOutput("filt_early", input_to_A, 8'hFF);
      applyStimulus(8'h5A, 1'b0, 1);
      checkOutput("filt_latency", input_to_A, 8'h5A);
      checkOutput("filt_B_idle", input_to_B, 8'hFF);

      // Glitch rejection and acceptance
      applyStimulus(8'hFF, 1'b0, 12);
      sawZeroA = 1'b0;
      applyStimulus(8'h00, 1'b0, 3);
      applyStimulus(8'hFF, 1'b0, 12);
      checkOutput("glitch3_rejected", {7'd0, sawZeroA}, 8'd0);
      applyStimulus(8'h00, 1'b0, 4);
      applyStimulus(8'hFF, 1'b0, 12);
      applyStimulus(8'h00, 1'b0, FL + 1);
      applyStimulus(8'hFF, 1'b0, 12);
      checkOutput("glitch_long_accepted", {7'd0, sawZeroA}, 8'd1);
      checkOutput("glitch_recovered", input_to_A, 8'hFF);

      // Changeover A -> B
      applyStimulus(8'hA5, 1'b0, 12);
      applyStimulus(8'hA5, 1'b1, 2);
      checkOutput("chg_sw_edge2", {7'd0, switching}, 8'd0);
      applyStimulus(8'hA5, 1'b1, 1);
      checkOutput("chg_sw_edge3", {7'd0, switching}, 8'd1);
      checkOutput("chg_A_edge3", input_to_A, 8'hA5);
      applyStimulus(8'hA5, 1'b1, 1);
      checkOutput("chg_A_idle", input_to_A, 8'hFF);
      applyStimulus(8'hA5, 1'b1, 6);
      checkOutput("chg_sw_edge10", {7'd0, switching}, 8'd1);
      checkOutput("chg_B_guard", input_to_B, 8'hFF);
      applyStimulus(8'hA5, 1'b1, 1);
      checkOutput("chg_sw_done", {7'd0, switching}, 8'd0);
      checkOutput("chg_sel", {7'd0, active_sel}, 8'd1);
      applyStimulus(8'hA5, 1'b1, 1);
      checkOutput("chg_B_data", input_to_B, 8'hA5);

      // Aborted switch returns to A after a restarted guard
      applyStimulus(8'hA5, 1'b0, 14);
      sawLiveB = 1'b0;
      applyStimulus(8'hA5, 1'b1, 5);
      applyStimulus(8'hA5, 1'b0, 10);
      checkOutput("abort_restart", {7'd0, switching}, 8'd1);
      applyStimulus(8'hA5, 1'b0, 1);
      checkOutput("abort_sw_done", {7'd0, switching}, 8'd0);
      checkOutput("abort_sel", {7'd0, active_sel}, 8'd0);
      applyStimulus(8'hA5, 1'b0, 1);
      checkOutput("abort_A_data", input_to_A, 8'hA5);
      checkOutput("abort_B_never", {7'd0, sawLiveB}, 8'd0);

      // Async reset in the middle of a guard
      applyStimulus(8'hA5, 1'b1, 5);
      checkOutput("arst_in_guard", {7'd0, switching}, 8'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_toA", input_to_A, 8'hFF);
      checkOutput("arst_toB", input_to_B, 8'hFF);
      checkOutput("arst_sel", {7'd0, active_sel}, 8'd0);
      checkOutput("arst_sw", {7'd0, switching}, 8'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      modelReset();
      applyStimulus(8'hA5, 1'b1, 2);
      checkOutput("arst_active_A", {7'd0, switching}, 8'd0);
      applyStimulus(8'hA5, 1'b1, 8);
      checkOutput("arst_full_guard", {7'd0, switching}, 8'd1);
      applyStimulus(8'hA5, 1'b1, 1);
      checkOutput("arst_B_granted", {7'd0, active_sel}, 8'd1);

      // Random pin and select traffic
      for (int seg = 0; seg < 120; seg++) begin
         logic [7:0] rPin;
         logic       rCtr;
         rPin = ($urandom_range(0, 3) == 0) ? input_pin : 8'($urandom_range(0, 255));
         rCtr = ($urandom_range(0, 3) == 0) ? ~ctr_io : ctr_io;
         applyStimulus(rPin, rCtr, $urandom_range(1, 14));
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
